// File: rtl/ad4003_frame_packer.sv
// AD4003 frame packer: per-channel block averaging of 18-bit signed conversions,
// emitted as header + sign-extended samples on a 32-bit AXI-Stream master.
// Completed periods that arrive while a frame is streaming are dropped and flagged.
module ad4003_frame_packer #(
   parameter int unsigned ADC_CHANNELS   = 8,
   parameter int unsigned ADC_DATA_WIDTH = 18,
   parameter int unsigned DECIM_LOG2     = 0
) (
   input  logic                                   adc_read_clk,
   input  logic                                   rst_n,
   input  logic                                   enable,
   input  logic                                   data_valid,
   input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
   input  logic                                   overrun_clr,
   output logic [31:0]                            m_axis_tdata,
   output logic                                   m_axis_tvalid,
   output logic                                   m_axis_tlast,
   input  logic                                   m_axis_tready,
   output logic                                   overrun,
   output logic [15:0]                            frame_cnt
);

   localparam int unsigned   AW        = ADC_DATA_WIDTH + DECIM_LOG2;
   localparam int unsigned   DW        = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int unsigned   IW        = $clog2(ADC_CHANNELS);
   localparam logic [DW-1:0] DCNT_LAST = DW'((32'd1 << DECIM_LOG2) - 32'd1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(ADC_CHANNELS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DAT  = 2'd2
   } state_t;

   state_t                           state_q, state_d;
   logic [IW-1:0]                    idx_q, idx_d;
   logic [DW-1:0]                    dcnt_q;
   logic [15:0]                      frame_cnt_q;
   logic [15:0]                      hdr_cnt_q;
   logic                             overrun_q;
   logic signed [AW-1:0]             acc_q [ADC_CHANNELS];
   logic signed [AW-1:0]             sum   [ADC_CHANNELS];
   logic signed [ADC_DATA_WIDTH-1:0] res   [ADC_CHANNELS];
   logic signed [ADC_DATA_WIDTH-1:0] buf_q [ADC_CHANNELS];
   logic                             strobe;
   logic                             period_done;
   logic                             capture;
   logic                             handshake;

   assign strobe      = data_valid && enable;
   assign period_done = strobe && (dcnt_q == DCNT_LAST);
   assign capture     = period_done && (state_q == IDLE);
   assign handshake   = m_axis_tvalid && m_axis_tready;

   // The first strobe of a period restarts the sum, so no separate clear is needed;
   // with DECIM_LOG2=0 every strobe is both first and last and the sample passes through.
   for (genvar k = 0; k < ADC_CHANNELS; k++) begin : g_ch
      logic signed [ADC_DATA_WIDTH-1:0] sample;
      assign sample = adc_data_arr[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
      assign sum[k] = (dcnt_q == '0) ? AW'(sample) : acc_q[k] + AW'(sample);
      assign res[k] = ADC_DATA_WIDTH'(sum[k] >>> DECIM_LOG2);
   end

   // Accumulators and position within the averaging period; disable drops partial periods
   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_q <= '0;
         for (int unsigned k = 0; k < ADC_CHANNELS; k++) acc_q[k] <= '0;
      end else if (!enable) begin
         dcnt_q <= '0;
         for (int unsigned k = 0; k < ADC_CHANNELS; k++) acc_q[k] <= '0;
      end else if (data_valid) begin
         dcnt_q <= period_done ? '0 : dcnt_q + DW'(1);
         for (int unsigned k = 0; k < ADC_CHANNELS; k++) acc_q[k] <= sum[k];
      end
   end

   // Period counter and sticky drop flag (a new drop beats a simultaneous clear)
   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         if (period_done) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (period_done && (state_q != IDLE)) overrun_q <= 1'b1;
         else if (overrun_clr)                 overrun_q <= 1'b0;
      end
   end

   // Output buffer: results and their period number latched only when the stream is idle
   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_cnt_q <= '0;
         for (int unsigned k = 0; k < ADC_CHANNELS; k++) buf_q[k] <= '0;
      end else if (capture) begin
         hdr_cnt_q <= frame_cnt_q + 16'd1;
         for (int unsigned k = 0; k < ADC_CHANNELS; k++) buf_q[k] <= res[k];
      end
   end

   // Stream FSM state register
   always_ff @(posedge adc_read_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Stream FSM next state: header, then one word per channel
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: if (period_done) state_d = HDR;
         HDR: if (handshake) begin
            state_d = DAT;
            idx_d   = '0;
         end
         DAT: if (handshake) begin
            if (idx_q == IDX_LAST) state_d = IDLE;
            else                   idx_d   = idx_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Stream outputs decoded from registered state only, so they hold under back-pressure
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state_q)
         HDR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {8'hAD, 8'(ADC_CHANNELS), hdr_cnt_q};
         end
         DAT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = 32'(buf_q[idx_q]);
            m_axis_tlast  = (idx_q == IDX_LAST);
         end
         default: ;
      endcase
   end

   assign overrun   = overrun_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ad4003_frame_packer.sv
// Bench for ad4003_frame_packer: two instances (pass-through and 4-sample averaging)
// share stimulus; a frame-level model predicts every output each cycle.
module tb_ad4003_frame_packer;

   localparam int CH = 8;
   localparam int W  = 18;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic           data_valid = 1'b0;
   logic [CH*W-1:0] din = '0;
   logic           overrun_clr = 1'b0;
   logic           tready = 1'b0;

   logic [31:0] tdata  [2];
   logic        tvalid [2];
   logic        tlast  [2];
   logic        ovr    [2];
   logic [15:0] fcnt   [2];

   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   ad4003_frame_packer #(.ADC_CHANNELS(CH), .ADC_DATA_WIDTH(W), .DECIM_LOG2(0)) u0 (
      .adc_read_clk(clk), .rst_n(rst_n), .enable(enable), .data_valid(data_valid),
      .adc_data_arr(din), .overrun_clr(overrun_clr),
      .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tlast(tlast[0]),
      .m_axis_tready(tready), .overrun(ovr[0]), .frame_cnt(fcnt[0]));

   ad4003_frame_packer #(.ADC_CHANNELS(CH), .ADC_DATA_WIDTH(W), .DECIM_LOG2(2)) u2 (
      .adc_read_clk(clk), .rst_n(rst_n), .enable(enable), .data_valid(data_valid),
      .adc_data_arr(din), .overrun_clr(overrun_clr),
      .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tlast(tlast[1]),
      .m_axis_tready(tready), .overrun(ovr[1]), .frame_cnt(fcnt[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int dl(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   // ---------------- behavioural model ----------------
   longint      sum_m   [2][CH];
   int          n_m     [2];
   int          fc_m    [2];
   bit          ovr_m   [2];
   bit          busy_m  [2];
   int          pos_m   [2];
   logic [31:0] frame_m [2][CH+1];
   bit          fresh_m [2];
   bit          drop_m  [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            n_m[i] = 0; fc_m[i] = 0; ovr_m[i] = 0; busy_m[i] = 0; pos_m[i] = 0;
            for (int k = 0; k < CH; k++) sum_m[i][k] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            fresh_m[i] = 0;
            drop_m[i]  = 0;
            if (!enable) begin
               n_m[i] = 0;
               for (int k = 0; k < CH; k++) sum_m[i][k] = 0;
            end else if (data_valid) begin
               for (int k = 0; k < CH; k++)
                  sum_m[i][k] += longint'($signed(din[k*W +: W]));
               n_m[i]++;
               if (n_m[i] == (1 << dl(i))) begin
                  fc_m[i] = (fc_m[i] + 1) % 65536;
                  if (busy_m[i]) drop_m[i] = 1;
                  else begin
                     fresh_m[i] = 1;
                     frame_m[i][0] = {8'hAD, 8'(CH), 16'(fc_m[i])};
                     for (int k = 0; k < CH; k++)
                        frame_m[i][k+1] = 32'(sum_m[i][k] >>> dl(i));
                  end
                  n_m[i] = 0;
                  for (int k = 0; k < CH; k++) sum_m[i][k] = 0;
               end
            end
            if (busy_m[i] && tready) begin
               pos_m[i]++;
               if (pos_m[i] == CH + 1) begin busy_m[i] = 0; pos_m[i] = 0; end
            end
            if (fresh_m[i]) begin busy_m[i] = 1; pos_m[i] = 0; end
            if (drop_m[i]) ovr_m[i] = 1;
            else if (overrun_clr) ovr_m[i] = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d.tvalid", i), 32'(tvalid[i]), 32'(busy_m[i]));
         if (busy_m[i]) begin
            chk($sformatf("u%0d.tdata", i), tdata[i], frame_m[i][pos_m[i]]);
            chk($sformatf("u%0d.tlast", i), 32'(tlast[i]), 32'(pos_m[i] == CH));
         end
         chk($sformatf("u%0d.overrun", i), 32'(ovr[i]), 32'(ovr_m[i]));
         chk($sformatf("u%0d.frame_cnt", i), 32'(fcnt[i]), 32'(fc_m[i]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic strobe(input logic [CH*W-1:0] d, input bit clr);
      cyc();
      din = d; data_valid = 1'b1; overrun_clr = clr;
      cyc();
      data_valid = 1'b0; overrun_clr = 1'b0;
   endtask

   function automatic logic [CH*W-1:0] rnd_word(input int ch0);
      logic [CH*W-1:0] d;
      for (int k = 0; k < CH; k++) d[k*W +: W] = W'($urandom);
      d[0 +: W] = W'(ch0);
      return d;
   endfunction

   logic [CH*W-1:0] ramp;
   int ch0v [4];
   int gap, stall;

   initial begin
      for (int k = 0; k < CH; k++) ramp[k*W +: W] = W'(k - 4);
      repeat (3) cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset.tvalid", 32'(tvalid[0]), 32'd0);
      chk("reset.tdata", tdata[0], 32'd0);
      chk("reset.frame_cnt", 32'(fcnt[0]), 32'd0);
      chk("reset.overrun", 32'(ovr[0]), 32'd0);

      // pass-through single strobe, ch k = k-4
      cyc(); enable = 1'b1; tready = 1'b1;
      strobe(ramp, 0);
      for (int j = 0; j <= CH; j++) begin
         @(negedge clk);
         chk("t1.word", tdata[0], (j == 0) ? 32'hAD080001 : 32'(j - 5));
         chk("t1.tlast", 32'(tlast[0]), 32'(j == CH));
      end
      repeat (10) cyc();

      // 4-sample average with the most negative input
      enable = 1'b0; cyc(); enable = 1'b1;
      ch0v = '{3, 4, -1, -131072};
      for (int s = 0; s < 4; s++) begin
         strobe(rnd_word(ch0v[s]), 0);
         if (s < 3) repeat (38) cyc();
      end
      @(negedge clk); chk("t2.hdr", tdata[1], 32'hAD080001);
      @(negedge clk); chk("t2.ch0", tdata[1], 32'hFFFF8001);
      repeat (40) cyc();

      // enable drop discards a partial period
      strobe(rnd_word(-50000), 0); repeat (38) cyc();
      strobe(rnd_word(-50000), 0); repeat (5) cyc();
      enable = 1'b0; repeat (5) cyc(); enable = 1'b1;
      ch0v = '{100, 200, 300, 401};
      for (int s = 0; s < 4; s++) begin
         strobe(rnd_word(ch0v[s]), 0);
         if (s < 3) repeat (38) cyc();
      end
      @(negedge clk); chk("t6.hdr", tdata[1], 32'hAD080002);
      @(negedge clk); chk("t6.ch0", tdata[1], 32'h000000FA);
      repeat (40) cyc();

      // back-pressure across three strobes
      tready = 1'b0;
      strobe(ramp, 0); repeat (38) cyc();
      strobe(ramp, 0); repeat (38) cyc();
      strobe(ramp, 0); repeat (18) cyc();
      @(negedge clk);
      chk("t3.frozen_hdr", tdata[0], 32'hAD08000C);
      chk("t3.frozen_tlast", 32'(tlast[0]), 32'd0);
      chk("t3.overrun", 32'(ovr[0]), 32'd1);
      chk("t3.frame_cnt", 32'(fcnt[0]), 32'd14);
      cyc(); tready = 1'b1;
      repeat (20) cyc();
      strobe(ramp, 0);
      @(negedge clk); chk("t3.next_hdr", tdata[0], 32'hAD08000F);
      repeat (20) cyc();

      // overrun clear: lone pulse clears, clear coincident with a drop loses
      overrun_clr = 1'b1; cyc(); overrun_clr = 1'b0;
      @(negedge clk); chk("t4.lone_clr", 32'(ovr[0]), 32'd0);
      cyc(); tready = 1'b0;
      strobe(ramp, 0); repeat (38) cyc();
      strobe(ramp, 1);
      @(negedge clk); chk("t4.set_wins", 32'(ovr[0]), 32'd1);
      cyc(); tready = 1'b1;
      repeat (20) cyc();

      // asynchronous reset in the middle of the data words
      strobe(ramp, 0);
      @(negedge clk); chk("t5.hdr", tdata[0], 32'hAD080012);
      repeat (4) @(negedge clk);
      chk("t5.idx3", tdata[0], 32'hFFFFFFFF);
      #1 rst_n = 1'b0;
      #1;
      chk("t5.rst_tvalid", 32'(tvalid[0]), 32'd0);
      chk("t5.rst_tdata", tdata[0], 32'd0);
      chk("t5.rst_tlast", 32'(tlast[0]), 32'd0);
      chk("t5.rst_fcnt", 32'(fcnt[0]), 32'd0);
      chk("t5.rst_ovr", 32'(ovr[1]), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      strobe(ramp, 0);
      @(negedge clk); chk("t5.hdr_after", tdata[0], 32'hAD080001);
      @(negedge clk); chk("t5.idx0_after", tdata[0], 32'hFFFFFFFC);
      repeat (15) cyc();

      // randomized traffic with stalls, clears and enable glitches
      gap = 5; stall = 0;
      for (int c = 0; c < 6000; c++) begin
         cyc();
         if (stall > 0) begin
            tready = 1'b0; stall--;
         end else begin
            tready = ($urandom % 4) != 0;
            if ($urandom % 150 == 0) stall = $urandom_range(20, 120);
         end
         overrun_clr = ($urandom % 60) == 0;
         enable = ($urandom % 250) != 0;
         if (gap == 0) begin
            data_valid = 1'b1;
            case ($urandom % 8)
               0: din = {CH{18'h20000}};
               1: din = {CH{18'h1FFFF}};
               default: din = rnd_word(int'($urandom));
            endcase
            gap = $urandom_range(40, 60);
         end else begin
            data_valid = 1'b0;
            gap--;
         end
      end
      data_valid = 1'b0; overrun_clr = 1'b0; tready = 1'b1; enable = 1'b1;
      repeat (30) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
